trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Machine-mode trap sequencer for the single-hart RV32 core. Sits beside the CSR unit at the commit point of the pipeline.
- Arbitrates between synchronous exceptions from the committing instruction and the three machine interrupt sources (external, software, timer). Also handles mret and wfi.
- Produces one-cycle CSR-update strobes (mepc/mcause/mtval) and a pipeline flush plus PC redirect.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the asynchronous interrupt-input synchronizer; legal range 2..4.
- XLEN, 32, data and address width.

Ports:
- clock  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- meip_i / msip_i / mtip_i  in  1 each  raw machine external / software / timer interrupt lines, asynchronous.
- commit_valid  in  1  an instruction is at commit this cycle.
- commit_pc  in  XLEN  PC of the committing instruction.
- exc_valid  in  1  committing instruction raised an exception; qualified by commit_valid.
- exc_cause  in  4  exception code (except_* encodings).
- exc_tval  in  XLEN  faulting address or instruction.
- mret_i  in  1  committing instruction is mret.
- wfi_i  in  1  committing instruction is wfi.
- mstatus_mie  in  1  global interrupt enable.
- mie_csr  in  XLEN  mie register.
- mtvec_csr  in  XLEN  mtvec register.
- mepc_csr  in  XLEN  current mepc, used as the mret target.
- mip_o  out  XLEN  synchronized pending bits at positions 3/7/11; all other bits 0.
- trap_we  out  1  one-cycle strobe: CSR unit writes mepc/mcause/mtval and stacks mstatus (MPIE<=MIE, MIE<=0, MPP<=m_mode).
- mret_we  out  1  one-cycle strobe: CSR unit unstacks mstatus (MIE<=MPIE, MPIE<=1).
- mepc_o / mcause_o / mtval_o  out  XLEN each  values written on trap_we.
- flush  out  1  kill every younger instruction.
- redirect_valid  out  1  fetch must restart at redirect_pc.
- redirect_pc  out  XLEN  restart address.
- busy  out  1  pipeline must not present a new commit.
- sleeping  out  1  core is in wfi.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, synchronizer chains cleared.
- Interrupt inputs pass through SYNC_STAGES flops, so a rising edge at cycle 0 is visible in mip_o at cycle SYNC_STAGES.
- Interrupt enabled = mip_o[k] & mie_csr[k] & mstatus_mie.
- Interrupt priority: MEI(11) > MSI(3) > MTI(7).
- Decision is made in IDLE only, on cycles with commit_valid. Priority order:
  1. exc_valid
  2. enabled interrupt
  3. mret_i
  4. wfi_i
  Anything not taken is an ordinary commit.
- An exception outranks a simultaneous interrupt. The interrupt stays pending and is re-evaluated at the next commit.
- An interrupt taken at commit kills the committing instruction:
  - mepc_o = commit_pc
  - mcause_o = {1, 27'b0, code}
  - mtval_o = 0
- Exception:
  - mepc_o = commit_pc
  - mcause_o = {0, 27'b0, exc_cause}
  - mtval_o = exc_tval
- FSM states: IDLE, TRAP, RET, WFI.
  - IDLE -> TRAP on exception or interrupt. Cause, mepc and mtval are latched at the decision edge, and busy rises in the decision cycle itself (combinational).
  - TRAP, lasting exactly 1 cycle: trap_we=flush=redirect_valid=1, redirect_pc = trap target; then -> IDLE.
  - IDLE -> RET on mret. RET, lasting 1 cycle: mret_we=flush=redirect_valid=1, redirect_pc = {mepc_csr[XLEN-1:2], 2'b00}; then -> IDLE.
  - IDLE -> WFI on wfi. In WFI: sleeping=1 and busy=1.
    - Leaves on mip_o & mie_csr != 0, regardless of mstatus_mie.
    - If the interrupt is also globally enabled: go to TRAP with mepc = wfi PC + 4 and the winning cause.
    - Otherwise: go to IDLE with flush=redirect_valid=1 and redirect_pc = wfi PC + 4, for that exit cycle only.
- Trap target, direct mode: {mtvec_csr[XLEN-1:2], 2'b00}.
- Decision-to-redirect latency: 1 cycle.
- Asserting reset in any state returns to IDLE immediately. Strobes drop asynchronously and no partial CSR write is issued.
- exc_valid, mret_i and wfi_i are ignored when commit_valid=0.
- PC + 4 arithmetic wraps modulo 2^XLEN.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- When defined and mtvec_csr[1:0]==01, an interrupt's redirect_pc = base + 4*code. Exceptions always go to base.
- When undefined, mtvec_csr[1:0] is ignored and every trap goes to base (direct mode only).

Decomposition:
- Shared package: add typedef enum trap_state_t {IDLE, TRAP, RET, WFI} and the 12-bit mip bit-position constants to the existing constants package. Interrupt/exception cause codes and m_mode are already there and are reused.
- One sub-module: irq_sync, a parameterized SYNC_STAGES-deep 3-bit synchronizer with asynchronous active-high reset.

Test Plan:
- mtvec=0x80000100; commit_valid, exc_valid, cause=2, pc=0x80000040, tval=0x0000FFFF -> next cycle:
  - trap_we=1, redirect_pc=0x80000100
  - mcause=0x00000002, mepc=0x80000040, mtval=0x0000FFFF
- mie=0x888, mstatus_mie=1, meip and mtip rise together; commit at pc 0x80000010 after sync -> mcause=0x8000000B, mtval=0. With TRAP_VECTORED_EN and mtvec=0x80000101 -> redirect_pc=0x8000012C.
- Same-cycle exc_valid (cause 4) and enabled msip -> exception taken first (mcause=4). The next commit then takes mcause=0x80000003.
- mret with mepc_csr=0x80000203 -> mret_we=1, redirect_pc=0x80000200, FSM back in IDLE one cycle later.
- wfi at pc 0x80000050 with mstatus_mie=0, then mtip with mie[7]=1 -> sleeping drops; redirect to 0x80000054; no trap_we.
- Reset asserted while in TRAP -> all strobes 0 immediately and FSM in IDLE.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - shared constants and types for the machine-mode trap sequencer
// Holds the trap FSM state type, the machine interrupt / exception cause codes,
// the privilege encoding and the mip bit positions and masks used by trap_ctrl.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRAP = 2'd1,
    RET  = 2'd2,
    WFI  = 2'd3
  } trap_state_t;

  localparam logic [1:0] M_MODE = 2'b11;

  // Interrupt cause codes (mcause[3:0] when mcause[XLEN-1] is set)
  localparam logic [3:0] IRQ_M_SOFT  = 4'd3;
  localparam logic [3:0] IRQ_M_TIMER = 4'd7;
  localparam logic [3:0] IRQ_M_EXT   = 4'd11;

  // Exception cause codes
  localparam logic [3:0] EXCEPT_INSN_MISALIGNED  = 4'd0;
  localparam logic [3:0] EXCEPT_INSN_FAULT       = 4'd1;
  localparam logic [3:0] EXCEPT_ILLEGAL_INSN     = 4'd2;
  localparam logic [3:0] EXCEPT_BREAKPOINT       = 4'd3;
  localparam logic [3:0] EXCEPT_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] EXCEPT_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] EXCEPT_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] EXCEPT_STORE_FAULT      = 4'd7;
  localparam logic [3:0] EXCEPT_ECALL_U          = 4'd8;
  localparam logic [3:0] EXCEPT_ECALL_M          = 4'd11;

  // mip / mie bit positions and 12-bit masks
  localparam int MIP_MSIP_BIT = 3;
  localparam int MIP_MTIP_BIT = 7;
  localparam int MIP_MEIP_BIT = 11;

  localparam logic [11:0] MIP_MSIP = 12'h008;
  localparam logic [11:0] MIP_MTIP = 12'h080;
  localparam logic [11:0] MIP_MEIP = 12'h800;

  // Fixed interrupt priority: external > software > timer.
  // Only meaningful when at least one of the three bits is set.
  function automatic logic [3:0] irq_winner(input logic [11:0] pend);
    if ((pend & MIP_MEIP) != 12'h000) begin
      return IRQ_M_EXT;
    end else if ((pend & MIP_MSIP) != 12'h000) begin
      return IRQ_M_SOFT;
    end else begin
      return IRQ_M_TIMER;
    end
  endfunction

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - multi-stage synchronizer for the three machine interrupt lines
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous active-high reset, clears every stage
//   async_in  in   raw interrupt lines {meip, mtip, msip}
//   sync_out  out  lines delayed by SYNC_STAGES rising edges
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] async_in,
  output logic [2:0] sync_out
);

  logic [SYNC_STAGES-1:0][2:0] chain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap sequencer at the commit point
// Arbitrates exceptions, machine interrupts, mret and wfi, and issues
// one-cycle CSR strobes plus a pipeline flush and PC redirect.
// Optional feature macro: TRAP_VECTORED_EN (vectored interrupt targets when mtvec[1:0]==01).
// Ports:
//   clock, reset                 clock and asynchronous active-high reset
//   meip_i, msip_i, mtip_i       raw asynchronous interrupt lines
//   commit_valid, commit_pc      committing instruction and its PC
//   exc_valid, exc_cause, exc_tval  exception raised by the committing instruction
//   mret_i, wfi_i                committing instruction is mret / wfi
//   mstatus_mie, mie_csr, mtvec_csr, mepc_csr  CSR views
//   mip_o                        synchronized pending bits (3/7/11)
//   trap_we, mret_we             one-cycle CSR update strobes
//   mepc_o, mcause_o, mtval_o    values written on trap_we
//   flush, redirect_valid, redirect_pc  pipeline kill and fetch restart
//   busy, sleeping               commit stall and wfi status
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int XLEN        = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            meip_i,
  input  logic            msip_i,
  input  logic            mtip_i,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_i,
  input  logic            wfi_i,
  input  logic            mstatus_mie,
  input  logic [XLEN-1:0] mie_csr,
  input  logic [XLEN-1:0] mtvec_csr,
  input  logic [XLEN-1:0] mepc_csr,
  output logic [XLEN-1:0] mip_o,
  output logic            trap_we,
  output logic            mret_we,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mtval_o,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy,
  output logic            sleeping
);

  trap_state_t state_q, state_d;

  logic [2:0]      irq_sync_q;
  logic [XLEN-1:0] pend;
  logic            irq_any;
  logic            irq_take;
  logic [XLEN-1:0] irq_cause_word;
  logic [XLEN-1:0] exc_cause_word;

  logic [XLEN-1:0] epc_q, cause_q, tval_q, wpc_q;
  logic [XLEN-1:0] epc_d, cause_d, tval_d;
  logic            latch_trap;
  logic            latch_wpc;
  logic [XLEN-1:0] trap_target;
  logic            unused_ok;

  irq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in ({meip_i, mtip_i, msip_i}),
    .sync_out (irq_sync_q)
  );

  always_comb begin
    mip_o = '0;
    mip_o[MIP_MEIP_BIT] = irq_sync_q[2];
    mip_o[MIP_MTIP_BIT] = irq_sync_q[1];
    mip_o[MIP_MSIP_BIT] = irq_sync_q[0];
  end

  // Locally enabled pending interrupts; mstatus_mie gates taking them, but a
  // locally enabled interrupt still wakes the core from wfi.
  assign pend     = mip_o & mie_csr;
  assign irq_any  = |pend;
  assign irq_take = irq_any & mstatus_mie;

  assign irq_cause_word = {1'b1, {(XLEN-5){1'b0}}, irq_winner(pend[11:0])};
  assign exc_cause_word = {1'b0, {(XLEN-5){1'b0}}, exc_cause};

  // Trap target is computed from the live mtvec while in TRAP; only latched
  // interrupts (mcause MSB set) may be vectored.
  always_comb begin
    trap_target = {mtvec_csr[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (mtvec_csr[1:0] == 2'b01 && cause_q[XLEN-1]) begin
      trap_target = trap_target + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
    end
`endif
  end

  always_comb begin
    state_d        = state_q;
    busy           = 1'b0;
    sleeping       = 1'b0;
    trap_we        = 1'b0;
    mret_we        = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    latch_trap     = 1'b0;
    latch_wpc      = 1'b0;
    epc_d          = commit_pc;
    cause_d        = exc_cause_word;
    tval_d         = exc_tval;

    case (state_q)
      IDLE: begin
        if (commit_valid) begin
          if (exc_valid) begin
            latch_trap = 1'b1;
            busy       = 1'b1;
            state_d    = TRAP;
          end else if (irq_take) begin
            // The committing instruction is killed and restarts after the handler.
            latch_trap = 1'b1;
            cause_d    = irq_cause_word;
            tval_d     = '0;
            busy       = 1'b1;
            state_d    = TRAP;
          end else if (mret_i) begin
            busy    = 1'b1;
            state_d = RET;
          end else if (wfi_i) begin
            latch_wpc = 1'b1;
            busy      = 1'b1;
            state_d   = WFI;
          end
        end
      end

      TRAP: begin
        trap_we        = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = trap_target;
        busy           = 1'b1;
        state_d        = IDLE;
      end

      RET: begin
        mret_we        = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = {mepc_csr[XLEN-1:2], 2'b00};
        busy           = 1'b1;
        state_d        = IDLE;
      end

      WFI: begin
        busy = 1'b1;
        if (irq_any) begin
          if (mstatus_mie) begin
            // Resume point of the handler is the instruction after wfi.
            latch_trap = 1'b1;
            epc_d      = wpc_q;
            cause_d    = irq_cause_word;
            tval_d     = '0;
            state_d    = TRAP;
          end else begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = wpc_q;
            state_d        = IDLE;
          end
        end else begin
          sleeping = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      epc_q   <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      wpc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_trap) begin
        epc_q   <= epc_d;
        cause_q <= cause_d;
        tval_q  <= tval_d;
      end
      if (latch_wpc) begin
        wpc_q <= commit_pc + XLEN'(4);
      end
    end
  end

  assign mepc_o   = epc_q;
  assign mcause_o = cause_q;
  assign mtval_o  = tval_q;

  assign unused_ok = ^{mtvec_csr[1:0], mepc_csr[1:0]};

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - self-checking bench for trap_ctrl
module tb_trap_ctrl;

  localparam int XLEN = 32;
  localparam int SS   = 2;

`ifdef TRAP_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            meip_i, msip_i, mtip_i;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_tval;
  logic            mret_i, wfi_i;
  logic            mstatus_mie;
  logic [XLEN-1:0] mie_csr, mtvec_csr, mepc_csr;
  logic [XLEN-1:0] mip_o;
  logic            trap_we, mret_we;
  logic [XLEN-1:0] mepc_o, mcause_o, mtval_o;
  logic            flush, redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy, sleeping;

  trap_ctrl #(.SYNC_STAGES(SS), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .meip_i(meip_i), .msip_i(msip_i), .mtip_i(mtip_i),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .mret_i(mret_i), .wfi_i(wfi_i),
    .mstatus_mie(mstatus_mie), .mie_csr(mie_csr), .mtvec_csr(mtvec_csr), .mepc_csr(mepc_csr),
    .mip_o(mip_o), .trap_we(trap_we), .mret_we(mret_we),
    .mepc_o(mepc_o), .mcause_o(mcause_o), .mtval_o(mtval_o),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .sleeping(sleeping)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    commit_valid = 1'b0;
    exc_valid    = 1'b0;
    mret_i       = 1'b0;
    wfi_i        = 1'b0;
  endtask

  // ---------------- table-driven single-commit vectors ----------------
  typedef struct {
    logic        meip, msip, mtip, gie;
    logic [31:0] mie, mtvec, mepc;
    logic        cv, exc;
    logic [3:0]  cause;
    logic [31:0] pc, tval;
    logic        mret, wfi;
    logic        busy_e, trap_e, mret_e;
    logic [31:0] rpc_e, mcause_e, mepc_e, mtval_e;
  } vec_t;

  vec_t tv[11];

  // ---------------- reference model ----------------
  logic [2:0]  m_q[$];
  int          m_kind;     // 0 nothing pending, 1 trap strobe due, 2 mret strobe due
  bit          m_sleep;
  logic [31:0] m_wpc, m_epc, m_cause, m_tval;

  function automatic logic [31:0] m_mip();
    logic [2:0] r;
    r = m_q[0];
    return (32'(r[2]) << 11) | (32'(r[1]) << 7) | (32'(r[0]) << 3);
  endfunction

  function automatic logic [31:0] m_win(input logic [31:0] p);
    if (p[11]) return 32'h8000000B;
    if (p[3])  return 32'h80000003;
    return 32'h80000007;
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] base;
    base = mtvec_csr & 32'hFFFFFFFC;
    if (VEC && (mtvec_csr & 32'h3) == 32'h1 && m_cause[31])
      return base + 32'd4 * (m_cause & 32'hF);
    return base;
  endfunction

  task automatic m_reset();
    m_q.delete();
    for (int i = 0; i < SS; i++) m_q.push_back(3'b000);
    m_kind  = 0;
    m_sleep = 0;
    m_wpc   = 0;
    m_epc   = 0;
    m_cause = 0;
    m_tval  = 0;
  endtask

  task automatic m_edge();
    logic [31:0] p;
    p = m_mip() & mie_csr;
    if (m_kind != 0) begin
      m_kind = 0;
    end else if (m_sleep) begin
      if (p != 0) begin
        m_sleep = 0;
        if (mstatus_mie) begin
          m_kind = 1; m_epc = m_wpc; m_cause = m_win(p); m_tval = 0;
        end
      end
    end else if (commit_valid) begin
      if (exc_valid) begin
        m_kind = 1; m_epc = commit_pc; m_cause = 32'(exc_cause); m_tval = exc_tval;
      end else if (p != 0 && mstatus_mie) begin
        m_kind = 1; m_epc = commit_pc; m_cause = m_win(p); m_tval = 0;
      end else if (mret_i) begin
        m_kind = 2;
      end else if (wfi_i) begin
        m_sleep = 1; m_wpc = commit_pc + 32'd4;
      end
    end
    void'(m_q.pop_front());
    m_q.push_back({meip_i, mtip_i, msip_i});
  endtask

  task automatic m_check();
    logic [31:0] p, e_rpc;
    logic e_trap, e_mret, e_rv, e_busy, e_sleep;
    p = m_mip() & mie_csr;
    e_trap = 0; e_mret = 0; e_rv = 0; e_busy = 0; e_sleep = 0; e_rpc = 0;
    if (m_kind == 1) begin
      e_trap = 1; e_rv = 1; e_busy = 1; e_rpc = m_target();
    end else if (m_kind == 2) begin
      e_mret = 1; e_rv = 1; e_busy = 1; e_rpc = mepc_csr & 32'hFFFFFFFC;
    end else if (m_sleep) begin
      e_busy = 1;
      if (p == 0) e_sleep = 1;
      else if (!mstatus_mie) begin e_rv = 1; e_rpc = m_wpc; end
    end else begin
      e_busy = commit_valid && (exc_valid || (p != 0 && mstatus_mie) || mret_i || wfi_i);
    end
    chk("rnd_mip", mip_o, m_mip());
    chk("rnd_trap_we", 32'(trap_we), 32'(e_trap));
    chk("rnd_mret_we", 32'(mret_we), 32'(e_mret));
    chk("rnd_flush", 32'(flush), 32'(e_rv));
    chk("rnd_redirect_valid", 32'(redirect_valid), 32'(e_rv));
    chk("rnd_redirect_pc", redirect_pc, e_rpc);
    chk("rnd_busy", 32'(busy), 32'(e_busy));
    chk("rnd_sleeping", 32'(sleeping), 32'(e_sleep));
    chk("rnd_mepc", mepc_o, m_epc);
    chk("rnd_mcause", mcause_o, m_cause);
    chk("rnd_mtval", mtval_o, m_tval);
  endtask

  function automatic logic [31:0] pick_mie();
    case ($urandom_range(0, 5))
      0: return 32'h888;
      1: return 32'h800;
      2: return 32'h080;
      3: return 32'h008;
      4: return 32'h0;
      default: return 32'hFFFFFFFF;
    endcase
  endfunction

  task automatic do_reset();
    idle_inputs();
    meip_i = 0; msip_i = 0; mtip_i = 0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    // field order: meip,msip,mtip,gie, mie,mtvec,mepc, cv,exc,cause, pc,tval, mret,wfi,
    //              busy_e,trap_e,mret_e, rpc_e,mcause_e,mepc_e,mtval_e
    tv[0]  = '{0,0,0,0, 32'h0,   32'h80000100, 32'h0,        1,1,4'd2,  32'h80000040, 32'h0000FFFF, 0,0, 1,1,0, 32'h80000100, 32'h2, 32'h80000040, 32'h0000FFFF};
    tv[1]  = '{1,0,1,1, 32'h888, 32'h80000101, 32'h0,        1,0,4'd0,  32'h80000010, 32'h12345678, 0,0, 1,1,0, VEC ? 32'h8000012C : 32'h80000100, 32'h8000000B, 32'h80000010, 32'h0};
    tv[2]  = '{0,1,1,1, 32'h888, 32'h80000101, 32'h0,        1,0,4'd0,  32'h80000020, 32'h0,        0,0, 1,1,0, VEC ? 32'h8000010C : 32'h80000100, 32'h80000003, 32'h80000020, 32'h0};
    tv[3]  = '{0,0,1,1, 32'h080, 32'h80000201, 32'h0,        1,0,4'd0,  32'h80000030, 32'h0,        0,0, 1,1,0, VEC ? 32'h8000021C : 32'h80000200, 32'h80000007, 32'h80000030, 32'h0};
    tv[4]  = '{0,0,1,0, 32'h080, 32'h80000100, 32'h0,        1,0,4'd0,  32'h80000034, 32'h0,        0,0, 0,0,0, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[5]  = '{1,0,0,1, 32'h008, 32'h80000100, 32'h0,        1,0,4'd0,  32'h80000038, 32'h0,        0,0, 0,0,0, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[6]  = '{1,0,0,1, 32'h800, 32'h80000101, 32'h0,        1,1,4'd4,  32'h8000003C, 32'h0000ABCD, 0,0, 1,1,0, 32'h80000100, 32'h4, 32'h8000003C, 32'h0000ABCD};
    tv[7]  = '{0,0,0,0, 32'h0,   32'h80000100, 32'h80000203, 0,1,4'd5,  32'h80000044, 32'h1,        1,1, 0,0,0, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[8]  = '{0,0,0,0, 32'h0,   32'h80000100, 32'h80000203, 1,0,4'd0,  32'h80000048, 32'h0,        1,0, 1,0,1, 32'h80000200, 32'h0, 32'h0, 32'h0};
    tv[9]  = '{0,0,0,0, 32'h0,   32'h00000004, 32'h80000203, 1,1,4'd11, 32'h0,        32'h0,        1,0, 1,1,0, 32'h4, 32'hB, 32'h0, 32'h0};
    tv[10] = '{1,0,0,1, 32'h800, 32'h80000100, 32'h80000300, 1,0,4'd0,  32'h80000060, 32'h0,        1,0, 1,1,0, 32'h80000100, 32'h8000000B, 32'h80000060, 32'h0};

    // reset state
    reset = 1'b1;
    idle_inputs();
    meip_i = 0; msip_i = 0; mtip_i = 0;
    commit_pc = 0; exc_cause = 0; exc_tval = 0;
    mstatus_mie = 0; mie_csr = 0; mtvec_csr = 0; mepc_csr = 0;
    #12;
    chk("rst_trap_we", 32'(trap_we), 0);
    chk("rst_mret_we", 32'(mret_we), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_redirect", {31'b0, redirect_valid} | redirect_pc, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sleeping", 32'(sleeping), 0);
    chk("rst_mip", mip_o, 0);
    chk("rst_csr_out", mepc_o | mcause_o | mtval_o, 0);
    tick();
    reset = 1'b0;
    tick();

    // table vectors
    for (int i = 0; i < 11; i++) begin
      meip_i = tv[i].meip; msip_i = tv[i].msip; mtip_i = tv[i].mtip;
      mstatus_mie = tv[i].gie; mie_csr = tv[i].mie;
      mtvec_csr = tv[i].mtvec; mepc_csr = tv[i].mepc;
      idle_inputs();
      repeat (SS + 1) tick();
      chk($sformatf("v%0d_mip", i), mip_o,
          (32'(tv[i].meip) << 11) | (32'(tv[i].mtip) << 7) | (32'(tv[i].msip) << 3));
      commit_valid = tv[i].cv; exc_valid = tv[i].exc; exc_cause = tv[i].cause;
      commit_pc = tv[i].pc; exc_tval = tv[i].tval; mret_i = tv[i].mret; wfi_i = tv[i].wfi;
      #1;
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].busy_e));
      tick();
      idle_inputs();
      chk($sformatf("v%0d_trap_we", i), 32'(trap_we), 32'(tv[i].trap_e));
      chk($sformatf("v%0d_mret_we", i), 32'(mret_we), 32'(tv[i].mret_e));
      chk($sformatf("v%0d_redirect_valid", i), 32'(redirect_valid), 32'(tv[i].trap_e | tv[i].mret_e));
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(tv[i].trap_e | tv[i].mret_e));
      if (tv[i].trap_e || tv[i].mret_e)
        chk($sformatf("v%0d_redirect_pc", i), redirect_pc, tv[i].rpc_e);
      if (tv[i].trap_e) begin
        chk($sformatf("v%0d_mcause", i), mcause_o, tv[i].mcause_e);
        chk($sformatf("v%0d_mepc", i), mepc_o, tv[i].mepc_e);
        chk($sformatf("v%0d_mtval", i), mtval_o, tv[i].mtval_e);
      end
      tick();
      chk($sformatf("v%0d_post_busy", i), 32'(busy), 0);
      chk($sformatf("v%0d_post_strobes", i), {30'b0, trap_we, mret_we}, 0);
      meip_i = 0; msip_i = 0; mtip_i = 0;
      repeat (SS + 1) tick();
    end

    // exception beats simultaneous msip; the next commit takes the interrupt
    mie_csr = 32'h008; mstatus_mie = 1; mtvec_csr = 32'h80000100; msip_i = 1;
    repeat (SS + 1) tick();
    commit_valid = 1; exc_valid = 1; exc_cause = 4'd4; commit_pc = 32'h80000070; exc_tval = 32'hDEAD;
    tick();
    idle_inputs();
    chk("seqA_exc_trap_we", 32'(trap_we), 1);
    chk("seqA_exc_mcause", mcause_o, 32'h4);
    tick();
    commit_valid = 1; commit_pc = 32'h80000074;
    #1;
    chk("seqA_irq_busy", 32'(busy), 1);
    tick();
    idle_inputs();
    chk("seqA_irq_trap_we", 32'(trap_we), 1);
    chk("seqA_irq_mcause", mcause_o, 32'h80000003);
    chk("seqA_irq_mepc", mepc_o, 32'h80000074);
    chk("seqA_irq_mtval", mtval_o, 32'h0);
    msip_i = 0;
    repeat (SS + 2) tick();

    // wfi with interrupts globally disabled: wake and resume at pc+4
    mie_csr = 32'h080; mstatus_mie = 0;
    commit_valid = 1; wfi_i = 1; commit_pc = 32'h80000050;
    #1;
    chk("seqC_wfi_busy", 32'(busy), 1);
    tick();
    idle_inputs();
    chk("seqC_sleeping", 32'(sleeping), 1);
    tick();
    chk("seqC_still_sleeping", 32'(sleeping), 1);
    mtip_i = 1;
    tick();
    chk("seqC_sync_sleeping", 32'(sleeping), 1);
    tick();
    chk("seqC_wake_sleeping", 32'(sleeping), 0);
    chk("seqC_wake_redirect_valid", 32'(redirect_valid), 1);
    chk("seqC_wake_flush", 32'(flush), 1);
    chk("seqC_wake_redirect_pc", redirect_pc, 32'h80000054);
    chk("seqC_wake_trap_we", 32'(trap_we), 0);
    tick();
    chk("seqC_after_redirect", {30'b0, redirect_valid, trap_we}, 0);
    chk("seqC_after_busy", 32'(busy), 0);
    mtip_i = 0;
    repeat (SS + 1) tick();

    // wfi with interrupts enabled: trap with mepc = wfi pc + 4, wrapping
    mie_csr = 32'h800; mstatus_mie = 1; mtvec_csr = 32'h80000100;
    commit_valid = 1; wfi_i = 1; commit_pc = 32'hFFFFFFFC;
    tick();
    idle_inputs();
    chk("seqD_sleeping", 32'(sleeping), 1);
    meip_i = 1;
    tick();
    tick();
    chk("seqD_wake_sleeping", 32'(sleeping), 0);
    chk("seqD_wake_no_redirect", 32'(redirect_valid), 0);
    chk("seqD_wake_busy", 32'(busy), 1);
    tick();
    chk("seqD_trap_we", 32'(trap_we), 1);
    chk("seqD_mepc_wrap", mepc_o, 32'h0);
    chk("seqD_mcause", mcause_o, 32'h8000000B);
    chk("seqD_redirect_pc", redirect_pc, 32'h80000100);
    meip_i = 0;
    repeat (SS + 2) tick();

    // reset asserted while in TRAP
    commit_valid = 1; exc_valid = 1; exc_cause = 4'd2; commit_pc = 32'h80000080; exc_tval = 32'h1;
    tick();
    idle_inputs();
    chk("seqE_in_trap", 32'(trap_we), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("seqE_rst_strobes", {29'b0, trap_we, mret_we, flush}, 0);
    chk("seqE_rst_redirect", 32'(redirect_valid), 0);
    chk("seqE_rst_busy", 32'(busy), 0);
    chk("seqE_rst_mepc", mepc_o, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("seqE_idle_trap_we", 32'(trap_we), 0);
    chk("seqE_idle_busy", 32'(busy), 0);

    // randomized run against the reference model
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock);
      m_edge();
      #1;
      if ($urandom_range(0, 15) == 0) meip_i = ~meip_i;
      if ($urandom_range(0, 15) == 0) msip_i = ~msip_i;
      if ($urandom_range(0, 15) == 0) mtip_i = ~mtip_i;
      if ($urandom_range(0, 3) == 0) mie_csr = pick_mie();
      mstatus_mie  = 1'($urandom_range(0, 1));
      mtvec_csr    = ($urandom & 32'hFFFFFFFC) | 32'($urandom_range(0, 1));
      mepc_csr     = $urandom;
      commit_valid = 1'($urandom_range(0, 1));
      exc_valid    = ($urandom_range(0, 4) == 0);
      mret_i       = ($urandom_range(0, 7) == 0);
      wfi_i        = ($urandom_range(0, 7) == 0);
      exc_cause    = 4'($urandom_range(0, 15));
      commit_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      exc_tval     = $urandom;
      #1;
      m_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
